// File: rtl/fixed4_col_sequencer.sv
// ---------------------------------------------------------------------------
// fixed4_col_sequencer
//
// Purpose: sequences one accumulation job through an external fixed-4 MAC
// datapath. A job is started from IDLE with a beat count and two sign flags.
// Each accepted operand beat is forwarded to the datapath together with the
// running accumulator. The combinational result is captured back into the
// accumulator. After the last beat, the result is held on out_psum until the
// consumer accepts it.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_start, cfg_len     job start request and beat count (1..255)
//   cfg_s_in, cfg_s_weight signed-mode flags for activations / weights
//   cfg_err                one-cycle pulse when a start with cfg_len=0 is rejected
//   busy                   high whenever the sequencer is not IDLE
//   in_valid/in_ready      operand stream handshake
//   in_act, in_wgt         two packed 4-bit lanes per byte
//   dp_in, dp_weight       operand drive to the MAC datapath
//   dp_s_in, dp_s_weight   sign flags to the MAC datapath (latched per job)
//   dp_psum_in             running accumulator to the MAC datapath
//   dp_psum_fwd            combinational MAC result from the datapath
//   out_valid/out_ready    result handshake
//   out_psum               final accumulated result
//   beat_cnt               beats consumed in the current or last job
// ---------------------------------------------------------------------------
module fixed4_col_sequencer #(
   parameter int COL_WIDTH = 11,
   parameter int PW        = 2 * COL_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_start,
   input  logic [7:0]    cfg_len,
   input  logic          cfg_s_in,
   input  logic          cfg_s_weight,
   output logic          cfg_err,
   output logic          busy,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_act,
   input  logic [7:0]    in_wgt,
   output logic [7:0]    dp_in,
   output logic [7:0]    dp_weight,
   output logic          dp_s_in,
   output logic          dp_s_weight,
   output logic [PW-1:0] dp_psum_in,
   input  logic [PW-1:0] dp_psum_fwd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_psum,
   output logic [7:0]    beat_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t        r_state;
   logic [7:0]    r_len;
   logic          r_s_in;
   logic          r_s_wgt;
   logic [PW-1:0] r_acc;
   logic [7:0]    r_beat_cnt;
   logic [PW-1:0] r_out_psum;
   logic          r_out_valid;
   logic          r_cfg_err;
   logic          r_busy;
   logic          r_in_ready;

   logic [7:0]    w_cnt_next;
   logic          w_beat;

   // Beat qualification and next count; in_ready is only ever set in RUN.
   assign w_cnt_next = r_beat_cnt + 8'd1;
   assign w_beat     = in_valid & r_in_ready;

   // Datapath drive: operands pass straight through, accumulator feeds back.
   assign dp_in       = in_act;
   assign dp_weight   = in_wgt;
   assign dp_s_in     = r_s_in;
   assign dp_s_weight = r_s_wgt;
   assign dp_psum_in  = r_acc;

   assign cfg_err   = r_cfg_err;
   assign busy      = r_busy;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_psum  = r_out_psum;
   assign beat_cnt  = r_beat_cnt;

   // Job sequencer FSM with registered status/handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_len       <= 8'd0;
         r_s_in      <= 1'b0;
         r_s_wgt     <= 1'b0;
         r_acc       <= '0;
         r_beat_cnt  <= 8'd0;
         r_out_psum  <= '0;
         r_out_valid <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         // cfg_err is a single-cycle pulse unless re-armed below.
         r_cfg_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg_start) begin
                  if (cfg_len != 8'd0) begin
                     r_len      <= cfg_len;
                     r_s_in     <= cfg_s_in;
                     r_s_wgt    <= cfg_s_weight;
                     r_acc      <= '0;
                     r_beat_cnt <= 8'd0;
                     r_busy     <= 1'b1;
                     r_in_ready <= 1'b1;
                     r_state    <= S_RUN;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_beat) begin
                  r_acc      <= dp_psum_fwd;
                  r_beat_cnt <= w_cnt_next;
                  // Last beat: the result goes out on the very same edge.
                  if (w_cnt_next == r_len) begin
                     r_out_psum  <= dp_psum_fwd;
                     r_out_valid <= 1'b1;
                     r_in_ready  <= 1'b0;
                     r_state     <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               // cfg_start is deliberately not looked at here, even on the
               // handshake cycle; a new job must be requested from IDLE.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fixed4_col_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fixed4_col_sequencer
//
// Directed bench for fixed4_col_sequencer. A behavioural fixed-4 MAC
// (two 4-bit lane products plus psum) closes the datapath loop. Expected
// results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fixed4_col_sequencer;

   localparam int COL_WIDTH = 11;
   localparam int PW        = 2 * COL_WIDTH;

   logic          clk;
   logic          rst_n;
   logic          cfg_start;
   logic [7:0]    cfg_len;
   logic          cfg_s_in;
   logic          cfg_s_weight;
   logic          cfg_err;
   logic          busy;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_act;
   logic [7:0]    in_wgt;
   logic [7:0]    dp_in;
   logic [7:0]    dp_weight;
   logic          dp_s_in;
   logic          dp_s_weight;
   logic [PW-1:0] dp_psum_in;
   logic [PW-1:0] dp_psum_fwd;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_psum;
   logic [7:0]    beat_cnt;

   int checks   = 0;
   int failures = 0;

   fixed4_col_sequencer #(.COL_WIDTH(COL_WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_start    (cfg_start),
      .cfg_len      (cfg_len),
      .cfg_s_in     (cfg_s_in),
      .cfg_s_weight (cfg_s_weight),
      .cfg_err      (cfg_err),
      .busy         (busy),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_act       (in_act),
      .in_wgt       (in_wgt),
      .dp_in        (dp_in),
      .dp_weight    (dp_weight),
      .dp_s_in      (dp_s_in),
      .dp_s_weight  (dp_s_weight),
      .dp_psum_in   (dp_psum_in),
      .dp_psum_fwd  (dp_psum_fwd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_psum     (out_psum),
      .beat_cnt     (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural fixed-4 MAC: lane-wise products with optional sign extension.
   logic signed [4:0] a0, a1, w0, w1;
   int                p_sum;
   always_comb begin
      a0 = {dp_s_in     & dp_in[3],     dp_in[3:0]};
      a1 = {dp_s_in     & dp_in[7],     dp_in[7:4]};
      w0 = {dp_s_weight & dp_weight[3], dp_weight[3:0]};
      w1 = {dp_s_weight & dp_weight[7], dp_weight[7:4]};
      p_sum = a0 * w0 + a1 * w1;
      dp_psum_fwd = dp_psum_in + PW'(p_sum);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_job(input logic [7:0] len, input logic si, input logic sw);
      cfg_start    = 1'b1;
      cfg_len      = len;
      cfg_s_in     = si;
      cfg_s_weight = sw;
      tick();
      cfg_start    = 1'b0;
   endtask

   task automatic beat(input logic [7:0] act, input logic [7:0] wgt);
      in_valid = 1'b1;
      in_act   = act;
      in_wgt   = wgt;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cfg_start = 1'b0; cfg_len = 8'd0; cfg_s_in = 1'b0;
      cfg_s_weight = 1'b0; in_valid = 1'b0; in_act = 8'd0; in_wgt = 8'd0;
      out_ready = 1'b0;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_cfg_err", cfg_err, 1'b0);
      chk("rst_beat_cnt", beat_cnt, 8'd0);
      chk("rst_out_psum", out_psum, 22'd0);
      chk("rst_dp_psum_in", dp_psum_in, 22'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", busy, 1'b0);

      // Unsigned job: 1*3+2*4 = 11, then 15*15*2 = 450 -> 461.
      out_ready = 1'b1;
      start_job(8'd2, 1'b0, 1'b0);
      chk("u_busy", busy, 1'b1);
      chk("u_in_ready", in_ready, 1'b1);
      chk("u_cnt0", beat_cnt, 8'd0);
      beat(8'h21, 8'h43);
      chk("u_cnt1", beat_cnt, 8'd1);
      chk("u_acc1", dp_psum_in, 22'd11);
      chk("u_valid_early", out_valid, 1'b0);
      beat(8'hFF, 8'hFF);
      chk("u_valid", out_valid, 1'b1);
      chk("u_psum", out_psum, 22'h0001CD);
      chk("u_cnt2", beat_cnt, 8'd2);
      chk("u_in_ready_hold", in_ready, 1'b0);
      tick();
      chk("u_valid_clr", out_valid, 1'b0);
      chk("u_busy_clr", busy, 1'b0);

      // Signed x signed: (-1)(-1)*2 = 2, then (-8)(-8)*2 = 128.
      start_job(8'd1, 1'b1, 1'b1);
      chk("ss_dp_s_in", dp_s_in, 1'b1);
      chk("ss_dp_s_w", dp_s_weight, 1'b1);
      beat(8'hFF, 8'hFF);
      chk("ss_psum_a", out_psum, 22'd2);
      chk("ss_valid_a", out_valid, 1'b1);
      tick();
      start_job(8'd1, 1'b1, 1'b1);
      beat(8'h88, 8'h88);
      chk("ss_psum_b", out_psum, 22'd128);
      tick();

      // Signed act x unsigned wgt: (-8)*1 + (-1)*1 = -9.
      start_job(8'd1, 1'b1, 1'b0);
      chk("su_dp_s_w", dp_s_weight, 1'b0);
      beat(8'hF8, 8'h11);
      chk("su_psum", out_psum, 22'h3FFFF7);
      tick();

      // Stalls in RUN, then backpressure in HOLD: 2 + 8 + 18 = 28.
      out_ready = 1'b0;
      start_job(8'd3, 1'b0, 1'b0);
      beat(8'h11, 8'h11);
      tick();
      tick();
      chk("st_cnt_frozen", beat_cnt, 8'd1);
      chk("st_acc_frozen", dp_psum_in, 22'd2);
      beat(8'h22, 8'h22);
      tick();
      chk("st_cnt2", beat_cnt, 8'd2);
      chk("st_acc2", dp_psum_in, 22'd10);
      beat(8'h33, 8'h33);
      chk("st_valid", out_valid, 1'b1);
      chk("st_psum", out_psum, 22'd28);
      cfg_start = 1'b1; cfg_len = 8'd5; cfg_s_in = 1'b1; cfg_s_weight = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_psum", out_psum, 22'd28);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_cfg_err", cfg_err, 1'b0);
         chk("bp_s_in", dp_s_in, 1'b0);
         chk("bp_cnt", beat_cnt, 8'd3);
      end
      out_ready = 1'b1;
      tick();
      chk("hs_valid_clr", out_valid, 1'b0);
      chk("hs_busy_clr", busy, 1'b0);
      cfg_start = 1'b0;
      tick();
      chk("hs_start_ignored", busy, 1'b0);
      chk("hs_cnt_held", beat_cnt, 8'd3);

      // Zero-length start is rejected with a single-cycle error pulse.
      cfg_start = 1'b1; cfg_len = 8'd0;
      tick();
      cfg_start = 1'b0;
      chk("z_cfg_err", cfg_err, 1'b1);
      chk("z_busy", busy, 1'b0);
      tick();
      chk("z_cfg_err_clr", cfg_err, 1'b0);
      chk("z_busy2", busy, 1'b0);

      // Reset after 1 of 3 beats abandons the job.
      start_job(8'd3, 1'b1, 1'b1);
      beat(8'h11, 8'h11);
      chk("r_cnt1", beat_cnt, 8'd1);
      rst_n = 1'b0;
      #1;
      chk("r_busy", busy, 1'b0);
      chk("r_in_ready", in_ready, 1'b0);
      chk("r_cnt", beat_cnt, 8'd0);
      chk("r_acc", dp_psum_in, 22'd0);
      chk("r_s_in", dp_s_in, 1'b0);
      chk("r_out_psum", out_psum, 22'd0);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1; in_act = 8'h11; in_wgt = 8'h11;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("r_no_valid", out_valid, 1'b0);
         chk("r_idle", busy, 1'b0);
         chk("r_cnt_zero", beat_cnt, 8'd0);
      end
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fixed4_col_sequencer.md
FIXED4_COL_SEQUENCER -- requirements
Module: fixed4_col_sequencer

Interface
REQ-001 SHALL have parameter COL_WIDTH, default 11, giving a partial-sum width PW = 2*COL_WIDTH.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_start, input, 1 bit: job start request, sampled only in IDLE.
REQ-005 SHALL have port cfg_len, input, 8 bits: number of operand beats in the job, 1..255.
REQ-006 SHALL have ports cfg_s_in and cfg_s_weight, input, 1 bit each: signed-mode flags for activations and weights.
REQ-007 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a start is rejected.
REQ-008 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_act (input, 8) and in_wgt (input, 8): operand stream, two packed 4-bit lanes per byte.
REQ-010 SHALL have ports dp_in (output, 8), dp_weight (output, 8), dp_s_in (output, 1), dp_s_weight (output, 1) and dp_psum_in (output, PW): drive to the fixed-4 MAC datapath.
REQ-011 SHALL have port dp_psum_fwd, input, PW bits: combinational result returned by the MAC datapath.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_psum (output, PW): result handshake.
REQ-013 SHALL have port beat_cnt, output, 8 bits: number of beats consumed in the current job.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and HOLD.
REQ-015 In IDLE, cfg_start=1 with cfg_len!=0 SHALL do all of the following: latch cfg_len, cfg_s_in and cfg_s_weight; clear the accumulator acc and beat_cnt to 0; go to RUN.
REQ-016 In IDLE, cfg_start=1 with cfg_len=0 SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-017 cfg_start outside IDLE SHALL be ignored: no cfg_err, no state change, latched config unchanged.
REQ-018 dp_s_in and dp_s_weight SHALL equal the latched flags, held constant for the whole job.
REQ-019 dp_in SHALL equal in_act, dp_weight SHALL equal in_wgt, and dp_psum_in SHALL equal acc, all combinationally.
REQ-020 in_ready SHALL be 1 only in RUN.
REQ-021 A beat SHALL be in_valid & in_ready; on a beat: acc <= dp_psum_fwd and beat_cnt <= beat_cnt+1.
REQ-022 A RUN cycle with in_valid=0 SHALL leave acc and beat_cnt unchanged (stall, no timeout).
REQ-023 On the beat where beat_cnt+1 equals the latched length, the FSM SHALL do all of the following in that edge: go to HOLD, set out_valid=1, load out_psum <= dp_psum_fwd.
REQ-024 In HOLD, out_valid and out_psum SHALL be stable until out_ready=1.
REQ-025 On out_valid & out_ready, the FSM SHALL clear out_valid and return to IDLE; result latency from the last beat is 1 clock.
REQ-026 A cfg_start in the same cycle as the HOLD-to-IDLE handshake SHALL be ignored; a new job needs cfg_start in IDLE.
REQ-027 Accumulation SHALL wrap modulo 2^PW, with no saturation and no overflow flag.
REQ-028 beat_cnt SHALL hold its final value through HOLD and IDLE until the next accepted start clears it.

Reset
REQ-029 While rst_n=0, the block SHALL force all of the following regardless of clk: state=IDLE; acc=0, beat_cnt=0, out_psum=0; out_valid=0, in_ready=0, busy=0, cfg_err=0; latched length and sign flags 0.
REQ-030 Reset asserted mid-RUN or mid-HOLD SHALL abandon the job, and no out_valid SHALL follow deassertion.
REQ-031 After rst_n rises, the first edge SHALL act in IDLE.

Verification
REQ-032 Unsigned job: cfg_len=2, flags 0/0; beats (in_act 0x21, in_wgt 0x43), then (0xFF, 0xFF); out_ready=1 -> out_valid one cycle after beat 2, out_psum=0x0001CD (461), beat_cnt=2, then IDLE.
REQ-033 Signed/signed: cfg_len=1, flags 1/1; beat (0xFF, 0xFF) -> out_psum=2; beat (0x88, 0x88) in a separate job -> 128.
REQ-034 Signed act / unsigned wgt: cfg_len=1, flags 1/0; beat (0xF8, 0x11) -> out_psum=0x3FFFF7 (-9) with COL_WIDTH=11.
REQ-035 Backpressure and stalls, both required:
- in_valid gaps during RUN -> acc and beat_cnt frozen.
- out_ready held 0 for 5 cycles in HOLD -> out_psum stable, in_ready=0, and extra cfg_start ignored.
REQ-036 Error and reset cases, both required:
- cfg_start with cfg_len=0 -> single-cycle cfg_err, busy stays 0.
- rst_n pulsed low after 1 of 3 beats -> IDLE, all outputs 0, no result.
